// File: rtl/m_code_pkg.sv
// Shared definitions for the m-code acquisition/tracking slice: FSM encoding,
// default window/threshold constants and the 31-chip m-sequence recurrence.
package m_code_pkg;

    localparam int CODE_LEN_DEF  = 31;
    localparam int LOCK_TH_DEF   = 28;
    localparam int CONFIRM_N_DEF = 2;
    localparam int MISS_N_DEF    = 3;

    // x^5 + x^2 + 1: feedback taps on s[4] (a[n]) and s[2] (a[n+2])
    localparam logic [4:0] M_TAPS = 5'b10100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SLIP   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_LOCK   = 3'd4
    } state_t;

    function automatic logic [4:0] m_next(input logic [4:0] s);
        return {s[3:0], ^(s & M_TAPS)};
    endfunction

endpackage

// File: rtl/m_code_sync_ctrl_if.sv
// Chip-stream and status bundle between the despreader/generator side and the
// code sync controller.
interface m_code_sync_ctrl_if #(
    parameter int CW = 5
);
    logic          enable;
    logic          chip_tick;
    logic          rx_chip;
    logic          local_chip;
    logic          shift_pulse;
    logic          locked;
    logic [CW-1:0] corr_val;
    logic          corr_valid;
    logic [CW-1:0] slip_cnt;
    logic          sweep_wrap;
    logic [2:0]    state;

    modport master (
        output enable, chip_tick, rx_chip, local_chip,
        input  shift_pulse, locked, corr_val, corr_valid, slip_cnt, sweep_wrap, state
    );

    modport slave (
        input  enable, chip_tick, rx_chip, local_chip,
        output shift_pulse, locked, corr_val, corr_valid, slip_cnt, sweep_wrap, state
    );
endinterface

// File: rtl/m_code_corr_win.sv
// Per-window chip agreement accumulator; one window is CODE_LEN counted ticks,
// with an optional discarded tick after each generator slip.
module m_code_corr_win
    import m_code_pkg::*;
#(
    parameter int CODE_LEN = CODE_LEN_DEF,
    parameter int LOCK_TH  = LOCK_TH_DEF,
    parameter int CW       = $clog2(CODE_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          count_en,
    input  logic          skip_set,
    input  logic          chip_tick,
    input  logic          rx_chip,
    input  logic          local_chip,
    output logic          win_end,
    output logic          hit,
    output logic [CW-1:0] corr_val,
    output logic          corr_valid
);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(CODE_LEN - 1);

    logic [CW-1:0] agree_cnt_r;
    logic [CW-1:0] chip_idx_r;
    logic          skip_r;
    logic [CW-1:0] corr_val_r;
    logic          corr_valid_r;

    logic          tick_s;
    logic          take_s;
    logic [CW-1:0] match_s;
    logic [CW-1:0] sum_s;

    // Tick qualification and the completed-window agreement total
    always_comb begin
        tick_s  = chip_tick && count_en;
        take_s  = tick_s && !skip_r;
        match_s = {{(CW-1){1'b0}}, ~(rx_chip ^ local_chip)};
        sum_s   = agree_cnt_r + match_s;
        win_end = take_s && (chip_idx_r == LAST);
        hit     = win_end && (sum_s >= CW'(LOCK_TH));
    end

    // Window counters, skip flag and the registered correlation result
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            agree_cnt_r  <= ZERO;
            chip_idx_r   <= ZERO;
            skip_r       <= 1'b0;
            corr_val_r   <= ZERO;
            corr_valid_r <= 1'b0;
        end else begin
            if (skip_set) begin
                skip_r <= 1'b1;
            end else if (tick_s && skip_r) begin
                skip_r <= 1'b0;
            end
            if (win_end) begin
                agree_cnt_r <= ZERO;
                chip_idx_r  <= ZERO;
                corr_val_r  <= sum_s;
            end else if (take_s) begin
                agree_cnt_r <= sum_s;
                chip_idx_r  <= chip_idx_r + ONE;
            end
            corr_valid_r <= win_end;
        end
    end

    assign corr_val   = corr_val_r;
    assign corr_valid = corr_valid_r;

endmodule

// File: rtl/m_code_sync_ctrl.sv
// Code phase acquisition/tracking controller: slides the local m-code one chip
// per missed window until correlation confirms, then holds and monitors lock.
module m_code_sync_ctrl
    import m_code_pkg::*;
#(
    parameter int CODE_LEN  = CODE_LEN_DEF,
    parameter int LOCK_TH   = LOCK_TH_DEF,
    parameter int CONFIRM_N = CONFIRM_N_DEF,
    parameter int MISS_N    = MISS_N_DEF,
    parameter int CW        = $clog2(CODE_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    m_code_sync_ctrl_if.slave bus
);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] hit_cnt_r;
    logic [CW-1:0] miss_cnt_r;
    logic [CW-1:0] slip_cnt_r;
    logic          shift_pulse_r;
    logic          locked_r;
    logic          sweep_wrap_r;

    logic          shift_pulse_s;
    logic          locked_s;
    logic          sweep_wrap_s;
    logic          count_en_s;
    logic          win_end_s;
    logic          hit_s;
    logic          confirm_s;
    logic          miss_last_s;
    logic          slip_last_s;

    assign count_en_s  = (state_r == ST_SEARCH) || (state_r == ST_VERIFY) || (state_r == ST_LOCK);
    assign confirm_s   = (hit_cnt_r + ONE) >= CW'(CONFIRM_N);
    assign miss_last_s = (miss_cnt_r + ONE) >= CW'(MISS_N);
    assign slip_last_s = (slip_cnt_r == CW'(CODE_LEN - 1));

    m_code_corr_win #(
        .CODE_LEN (CODE_LEN),
        .LOCK_TH  (LOCK_TH),
        .CW       (CW)
    ) u_corr_win (
        .clk        (clk),
        .rst        (rst),
        .clr        (!bus.enable),
        .count_en   (count_en_s),
        .skip_set   (state_r == ST_SLIP),
        .chip_tick  (bus.chip_tick),
        .rx_chip    (bus.rx_chip),
        .local_chip (bus.local_chip),
        .win_end    (win_end_s),
        .hit        (hit_s),
        .corr_val   (bus.corr_val),
        .corr_valid (bus.corr_valid)
    );

    // State register together with the registered FSM outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            shift_pulse_r <= 1'b0;
            locked_r      <= 1'b0;
            sweep_wrap_r  <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            shift_pulse_r <= shift_pulse_s;
            locked_r      <= locked_s;
            sweep_wrap_r  <= sweep_wrap_s;
        end
    end

    // Next-state decision; dropping enable wins over any window-end outcome
    always_comb begin
        next_state_s = state_r;
        if (!bus.enable) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   next_state_s = ST_SEARCH;
                ST_SEARCH: begin
                    if (win_end_s && hit_s) begin
                        next_state_s = (CONFIRM_N == 1) ? ST_LOCK : ST_VERIFY;
                    end else if (win_end_s) begin
                        next_state_s = ST_SLIP;
                    end else begin
                        next_state_s = ST_SEARCH;
                    end
                end
                ST_VERIFY: begin
                    if (win_end_s && hit_s) begin
                        next_state_s = confirm_s ? ST_LOCK : ST_VERIFY;
                    end else if (win_end_s) begin
                        next_state_s = ST_SLIP;
                    end else begin
                        next_state_s = ST_VERIFY;
                    end
                end
                ST_SLIP:   next_state_s = ST_SEARCH;
                ST_LOCK: begin
                    if (win_end_s && !hit_s && miss_last_s) begin
                        next_state_s = ST_SLIP;
                    end else begin
                        next_state_s = ST_LOCK;
                    end
                end
                default:   next_state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode, registered on the same edge as the state change
    always_comb begin
        shift_pulse_s = (next_state_s == ST_SLIP);
        locked_s      = (next_state_s == ST_LOCK);
        sweep_wrap_s  = bus.enable && (state_r == ST_SLIP) && slip_last_s;
    end

    // Hit/miss/slip bookkeeping; all cleared while disabled
    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            hit_cnt_r  <= ZERO;
            miss_cnt_r <= ZERO;
            slip_cnt_r <= ZERO;
        end else begin
            case (state_r)
                ST_IDLE:   slip_cnt_r <= ZERO;
                ST_SEARCH: begin
                    if (win_end_s && hit_s) begin
                        hit_cnt_r  <= ONE;
                        miss_cnt_r <= ZERO;
                    end
                end
                ST_VERIFY: begin
                    if (win_end_s && hit_s) begin
                        hit_cnt_r  <= hit_cnt_r + ONE;
                        miss_cnt_r <= ZERO;
                    end else if (win_end_s) begin
                        hit_cnt_r <= ZERO;
                    end
                end
                ST_SLIP:   slip_cnt_r <= slip_last_s ? ZERO : slip_cnt_r + ONE;
                ST_LOCK: begin
                    if (win_end_s && hit_s) begin
                        miss_cnt_r <= ZERO;
                    end else if (win_end_s && miss_last_s) begin
                        miss_cnt_r <= ZERO;
                        hit_cnt_r  <= ZERO;
                        slip_cnt_r <= ZERO;
                    end else if (win_end_s) begin
                        miss_cnt_r <= miss_cnt_r + ONE;
                    end
                end
                default: begin
                    hit_cnt_r  <= ZERO;
                    miss_cnt_r <= ZERO;
                    slip_cnt_r <= ZERO;
                end
            endcase
        end
    end

    assign bus.shift_pulse = shift_pulse_r;
    assign bus.locked      = locked_r;
    assign bus.sweep_wrap  = sweep_wrap_r;
    assign bus.slip_cnt    = slip_cnt_r;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_m_code_sync_ctrl.sv
// Directed bench for m_code_sync_ctrl: a bench-side m-code generator that
// honours shift_pulse, with rx derived from an independent phase of the code.
module tb_m_code_sync_ctrl;
    import m_code_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m_code_sync_ctrl_if bus ();

    m_code_sync_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   errors = 0;
    int   checks = 0;
    bit   mseq [31];
    int   rx_phase, loc_phase, cyc, flip_left;
    bit   hold_pend, inv, noise;
    logic [6:0] nz;
    int   n_shift, n_wrap, n_locked;

    // One clock: observe outputs at the negedge, then drive the next inputs
    task automatic step();
        @(negedge clk);
        if (bus.shift_pulse) begin n_shift++; hold_pend = 1'b1; end
        if (bus.sweep_wrap) n_wrap++;
        if (bus.locked) n_locked++;
        cyc++;
        if (cyc % 4 == 0) begin
            bus.local_chip = mseq[loc_phase];
            bus.rx_chip    = (noise ? nz[6] : mseq[rx_phase]) ^ inv ^ (flip_left != 0);
            if (flip_left != 0) flip_left--;
            if (hold_pend) hold_pend = 1'b0;
            else loc_phase = (loc_phase == 30) ? 0 : loc_phase + 1;
            rx_phase = (rx_phase == 30) ? 0 : rx_phase + 1;
            nz = {nz[5:0], nz[6] ^ nz[5]};
            bus.chip_tick = 1'b1;
        end else begin
            bus.chip_tick = 1'b0;
        end
    endtask

    task automatic wait_win(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus.corr_valid) begin ok = 1'b1; break; end
        end
    endtask

    // Reset, clear the models, then enable with local leading rx by 'offset'
    task automatic start(input int offset);
        rst = 1'b1; bus.enable = 1'b0;
        step(); step();
        rx_phase = 0; loc_phase = offset; hold_pend = 1'b0;
        inv = 1'b0; noise = 1'b0; flip_left = 0; nz = 7'h5A;
        n_shift = 0; n_wrap = 0; n_locked = 0;
        rst = 1'b0; bus.enable = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.enable = 1'b1;
        bus.chip_tick = 1'b0; bus.rx_chip = 1'b0; bus.local_chip = 1'b0;
        step(); step(); step();
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", bus.state);
        end
        checks++;
        if ({bus.shift_pulse, bus.locked, bus.corr_valid, bus.sweep_wrap, bus.corr_val, bus.slip_cnt} !== 14'd0) begin
            errors++; $display("FAIL reset_outputs: got sp=%0b lk=%0b cv=%0b sw=%0b corr=%0d slip=%0d want all 0",
                bus.shift_pulse, bus.locked, bus.corr_valid, bus.sweep_wrap, bus.corr_val, bus.slip_cnt);
        end
    endtask

    task automatic test_aligned();
        bit ok;
        start(0);
        wait_win(ok);
        checks++;
        if (!ok || bus.corr_val !== 5'd31 || bus.state !== 3'd3 || bus.locked !== 1'b0) begin
            errors++; $display("FAIL aligned_win1: got ok=%0b corr=%0d st=%0d lk=%0b want corr=31 st=3 lk=0",
                ok, bus.corr_val, bus.state, bus.locked);
        end
        wait_win(ok);
        checks++;
        if (!ok || bus.corr_val !== 5'd31 || bus.state !== 3'd4 || bus.locked !== 1'b1) begin
            errors++; $display("FAIL aligned_win2: got ok=%0b corr=%0d st=%0d lk=%0b want corr=31 st=4 lk=1",
                ok, bus.corr_val, bus.state, bus.locked);
        end
        checks++;
        if (n_shift != 0) begin
            errors++; $display("FAIL aligned_shifts: got %0d want 0", n_shift);
        end
    endtask

    task automatic test_offset();
        bit ok;
        start(5);
        for (int w = 0; w < 5; w++) begin
            wait_win(ok);
            checks++;
            if (!ok || bus.corr_val !== 5'd15 || bus.shift_pulse !== 1'b1 || bus.state !== 3'd2) begin
                errors++; $display("FAIL offset_miss%0d: got ok=%0b corr=%0d sp=%0b st=%0d want corr=15 sp=1 st=2",
                    w, ok, bus.corr_val, bus.shift_pulse, bus.state);
            end
        end
        wait_win(ok);
        checks++;
        if (!ok || bus.corr_val !== 5'd31 || bus.state !== 3'd3 || bus.slip_cnt !== 5'd5) begin
            errors++; $display("FAIL offset_verify: got ok=%0b corr=%0d st=%0d slip=%0d want corr=31 st=3 slip=5",
                ok, bus.corr_val, bus.state, bus.slip_cnt);
        end
        wait_win(ok);
        checks++;
        if (!ok || bus.corr_val !== 5'd31 || bus.locked !== 1'b1) begin
            errors++; $display("FAIL offset_lock: got ok=%0b corr=%0d lk=%0b want corr=31 lk=1", ok, bus.corr_val, bus.locked);
        end
        checks++;
        if (n_shift != 5) begin
            errors++; $display("FAIL offset_shifts: got %0d want 5", n_shift);
        end
    endtask

    task automatic test_no_signal();
        start(0);
        noise = 1'b1;
        for (int i = 0; i < 6000 && n_shift < 31; i++) step();
        step(); step();
        checks++;
        if (n_shift != 31 || n_wrap != 1 || bus.slip_cnt !== 5'd0) begin
            errors++; $display("FAIL sweep_wrap: got shifts=%0d wraps=%0d slip=%0d want 31 1 0", n_shift, n_wrap, bus.slip_cnt);
        end
        for (int i = 0; i < 1000 && n_shift < 33; i++) step();
        step(); step();
        checks++;
        if (n_shift != 33 || n_wrap != 1 || bus.slip_cnt !== 5'd2 || n_locked != 0) begin
            errors++; $display("FAIL sweep_after: got shifts=%0d wraps=%0d slip=%0d locked_cycles=%0d want 33 1 2 0",
                n_shift, n_wrap, bus.slip_cnt, n_locked);
        end
    endtask

    task automatic test_lock_hold_loss();
        bit ok;
        int base;
        start(0);
        wait_win(ok); wait_win(ok);
        flip_left = 4;
        wait_win(ok);
        checks++;
        if (!ok || bus.corr_val !== 5'd27 || bus.locked !== 1'b1 || dut.miss_cnt_r !== 5'd1) begin
            errors++; $display("FAIL hold_miss: got ok=%0b corr=%0d lk=%0b miss=%0d want corr=27 lk=1 miss=1",
                ok, bus.corr_val, bus.locked, dut.miss_cnt_r);
        end
        wait_win(ok);
        checks++;
        if (!ok || bus.corr_val !== 5'd31 || bus.locked !== 1'b1 || dut.miss_cnt_r !== 5'd0) begin
            errors++; $display("FAIL hold_recover: got ok=%0b corr=%0d lk=%0b miss=%0d want corr=31 lk=1 miss=0",
                ok, bus.corr_val, bus.locked, dut.miss_cnt_r);
        end
        inv = 1'b1;
        base = n_shift;
        wait_win(ok);
        checks++;
        if (!ok || bus.corr_val > 5'd1 || bus.locked !== 1'b1) begin
            errors++; $display("FAIL loss_miss1: got ok=%0b corr=%0d lk=%0b want corr<=1 lk=1", ok, bus.corr_val, bus.locked);
        end
        wait_win(ok);
        checks++;
        if (!ok || bus.corr_val !== 5'd0 || bus.locked !== 1'b1) begin
            errors++; $display("FAIL loss_miss2: got ok=%0b corr=%0d lk=%0b want corr=0 lk=1", ok, bus.corr_val, bus.locked);
        end
        wait_win(ok);
        checks++;
        if (!ok || bus.locked !== 1'b0 || bus.shift_pulse !== 1'b1 || bus.state !== 3'd2) begin
            errors++; $display("FAIL loss_miss3: got ok=%0b lk=%0b sp=%0b st=%0d want lk=0 sp=1 st=2",
                ok, bus.locked, bus.shift_pulse, bus.state);
        end
        step();
        checks++;
        if (bus.slip_cnt !== 5'd1 || bus.state !== 3'd1 || n_shift - base != 1) begin
            errors++; $display("FAIL loss_slip: got slip=%0d st=%0d shifts=%0d want 1 1 1",
                bus.slip_cnt, bus.state, n_shift - base);
        end
    endtask

    task automatic test_enable_override();
        bit ok;
        start(2);
        wait_win(ok); wait_win(ok); wait_win(ok);
        checks++;
        if (!ok || bus.state !== 3'd3 || bus.slip_cnt !== 5'd2) begin
            errors++; $display("FAIL ovr_verify: got ok=%0b st=%0d slip=%0d want st=3 slip=2", ok, bus.state, bus.slip_cnt);
        end
        repeat (40) step();
        bus.enable = 1'b0;
        step();
        checks++;
        if ({bus.state, bus.shift_pulse, bus.locked, bus.corr_valid, bus.sweep_wrap, bus.corr_val, bus.slip_cnt} !== 17'd0) begin
            errors++; $display("FAIL ovr_idle: got st=%0d sp=%0b lk=%0b cv=%0b sw=%0b corr=%0d slip=%0d want all 0",
                bus.state, bus.shift_pulse, bus.locked, bus.corr_valid, bus.sweep_wrap, bus.corr_val, bus.slip_cnt);
        end
        bus.enable = 1'b1;
        step();
        checks++;
        if (bus.state !== 3'd1 || bus.slip_cnt !== 5'd0) begin
            errors++; $display("FAIL ovr_reenable: got st=%0d slip=%0d want st=1 slip=0", bus.state, bus.slip_cnt);
        end
        wait_win(ok);
        checks++;
        if (!ok || bus.corr_val !== 5'd31 || bus.state !== 3'd3) begin
            errors++; $display("FAIL ovr_restart_win: got ok=%0b corr=%0d st=%0d want corr=31 st=3", ok, bus.corr_val, bus.state);
        end
    endtask

    task automatic test_reset_in_slip();
        bit ok;
        start(3);
        wait_win(ok);
        checks++;
        if (!ok || bus.shift_pulse !== 1'b1 || bus.state !== 3'd2) begin
            errors++; $display("FAIL rst_slip_enter: got ok=%0b sp=%0b st=%0d want sp=1 st=2", ok, bus.shift_pulse, bus.state);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.shift_pulse !== 1'b0 || bus.state !== 3'd0 || bus.slip_cnt !== 5'd0) begin
            errors++; $display("FAIL rst_slip: got sp=%0b st=%0d slip=%0d want 0 0 0", bus.shift_pulse, bus.state, bus.slip_cnt);
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] s;
        s = 5'b00001;
        for (int i = 0; i < 31; i++) begin
            mseq[i] = s[4];
            s = m_next(s);
        end
        cyc = 0; rx_phase = 0; loc_phase = 0; flip_left = 0;
        hold_pend = 1'b0; inv = 1'b0; noise = 1'b0; nz = 7'h5A;
        n_shift = 0; n_wrap = 0; n_locked = 0;
        bus.enable = 1'b0; bus.chip_tick = 1'b0; bus.rx_chip = 1'b0; bus.local_chip = 1'b0;
        test_reset();
        test_aligned();
        test_offset();
        test_no_signal();
        test_lock_hold_loss();
        test_enable_override();
        test_reset_in_slip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
